// File: rtl/if_inst_queue.sv
// Instruction queue between inst_fetch and decode.
// Buffers {pc, inst} pairs in a DEPTH-entry circular FIFO with valid/ready
// handshakes on both sides; i_flush drops every buffered word on a redirect.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_valid/o_if_ready     fetch-side handshake
//   i_if_pc, i_if_inst        fetched word
//   i_flush                   discard all queued words
//   o_id_valid/i_id_ready     decode-side handshake
//   o_id_pc, o_id_inst        head entry (zero when empty)
//   o_count                   number of occupied entries
module if_inst_queue #(
    parameter int unsigned NPC   = 6,
    parameter int unsigned NINST = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_if_valid,
    output logic                         o_if_ready,
    input  logic [NPC-1:0]               i_if_pc,
    input  logic [NINST-1:0]             i_if_inst,
    input  logic                         i_flush,
    output logic                         o_id_valid,
    input  logic                         i_id_ready,
    output logic [NPC-1:0]               o_id_pc,
    output logic [NINST-1:0]             o_id_inst,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = NPC + NINST;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // Handshake flags come only from the registered count (no full bypass).
    assign o_if_ready = (count != CW'(DEPTH));
    assign o_id_valid = (count != '0);
    assign o_count    = count;

    assign push = i_if_valid && o_if_ready && !i_flush;
    assign pop  = o_id_valid && i_id_ready && !i_flush;

    // Stale storage is masked so the head reads zero when empty.
    assign head      = o_id_valid ? mem[rd_ptr] : '0;
    assign o_id_pc   = head[EW-1:NINST];
    assign o_id_inst = head[NINST-1:0];

    // Pointer and occupancy update; reset, then flush, take priority.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy masks its contents.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= {i_if_pc, i_if_inst};
        end
    end

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed self-checking bench for if_inst_queue (NPC=6, NINST=32, DEPTH=4).
module tb_if_inst_queue;

    localparam int unsigned NPC   = 6;
    localparam int unsigned NINST = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] IBASE = 32'h1000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_valid = 1'b0;
    logic             if_ready;
    logic [NPC-1:0]   if_pc = '0;
    logic [NINST-1:0] if_inst = '0;
    logic             flush = 1'b0;
    logic             id_valid;
    logic             id_ready = 1'b0;
    logic [NPC-1:0]   id_pc;
    logic [NINST-1:0] id_inst;
    logic [2:0]       count;

    int n_checks = 0;
    int n_fail   = 0;

    if_inst_queue #(.NPC(NPC), .NINST(NINST), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_if_valid (if_valid),
        .o_if_ready (if_ready),
        .i_if_pc    (if_pc),
        .i_if_inst  (if_inst),
        .i_flush    (flush),
        .o_id_valid (id_valid),
        .i_id_ready (id_ready),
        .o_id_pc    (id_pc),
        .o_id_inst  (id_inst),
        .o_count    (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int pc);
        if_valid = 1'b1;
        if_pc    = NPC'(pc);
        if_inst  = IBASE + 32'(pc);
    endtask

    int push_pc;
    int exp_pop;
    int mcount;
    bit push_acc;
    bit pop_acc;

    initial begin
        // Reset held for two edges.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_valid", 64'(id_valid), 64'd0);
        check_eq("rst_ready", 64'(if_ready), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_pc",    64'(id_pc), 64'd0);
        check_eq("rst_inst",  64'(id_inst), 64'd0);

        // Fill to full with decode stalled.
        id_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            present(p);
            step();
        end
        check_eq("full_count", 64'(count), 64'd4);
        check_eq("full_ready", 64'(if_ready), 64'd0);
        present(4);
        step();
        step();
        check_eq("held_count", 64'(count), 64'd4);
        check_eq("held_pc",    64'(id_pc), 64'd0);
        check_eq("held_inst",  64'(id_inst), 64'h1000_0000);

        // Drain in order.
        if_valid = 1'b0;
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("drain_valid", 64'(id_valid), 64'd1);
            check_eq("drain_pc",    64'(id_pc), 64'(k));
            step();
        end
        check_eq("empty_valid", 64'(id_valid), 64'd0);
        check_eq("empty_count", 64'(count), 64'd0);

        // Simultaneous push/pop with two entries resident.
        id_ready = 1'b0;
        present(10); step();
        present(11); step();
        check_eq("pp_start_count", 64'(count), 64'd2);
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present(12 + i);
            check_eq("pp_pc", 64'(id_pc), 64'(10 + i));
            step();
            check_eq("pp_count", 64'(count), 64'd2);
        end
        if_valid = 1'b0;
        check_eq("pp_tail0", 64'(id_pc), 64'd18);
        step();
        check_eq("pp_tail1", 64'(id_pc), 64'd19);
        step();
        check_eq("pp_end_count", 64'(count), 64'd0);

        // Wrap-around stream with decode ready toggling 1,0.
        push_pc = 0;
        exp_pop = 0;
        mcount  = 0;
        for (int cyc = 0; cyc < 60 && exp_pop < 10; cyc++) begin
            id_ready = (cyc % 2 == 0);
            if (push_pc < 10) present(push_pc);
            else if_valid = 1'b0;
            push_acc = (push_pc < 10) && (mcount != DEPTH);
            pop_acc  = id_ready && (mcount != 0);
            check_eq("wrap_count", 64'(count), 64'(mcount));
            check_eq("wrap_ready", 64'(if_ready), 64'(mcount != DEPTH));
            if (pop_acc) begin
                check_eq("wrap_pc",   64'(id_pc), 64'(exp_pop));
                check_eq("wrap_inst", 64'(id_inst), 64'(IBASE + 32'(exp_pop)));
            end
            step();
            if (push_acc) begin push_pc++; mcount++; end
            if (pop_acc)  begin exp_pop++; mcount--; end
        end
        if_valid = 1'b0;
        id_ready = 1'b0;
        check_eq("wrap_all_popped", 64'(exp_pop), 64'd10);
        check_eq("wrap_end_count",  64'(count), 64'd0);
        check_eq("wrap_end_valid",  64'(id_valid), 64'd0);

        // Flush with a concurrent push, then the same with reset.
        for (int pass = 0; pass < 2; pass++) begin
            id_ready = 1'b0;
            for (int p = 1; p <= 3; p++) begin
                present(p);
                step();
            end
            check_eq("pre_count", 64'(count), 64'd3);
            present(7);
            if (pass == 0) flush = 1'b1;
            else rst = 1'b1;
            step();
            flush    = 1'b0;
            rst      = 1'b0;
            if_valid = 1'b0;
            check_eq("redir_count", 64'(count), 64'd0);
            check_eq("redir_valid", 64'(id_valid), 64'd0);
            check_eq("redir_ready", 64'(if_ready), 64'd1);
            check_eq("redir_pc",    64'(id_pc), 64'd0);
            check_eq("redir_inst",  64'(id_inst), 64'd0);
            present(5);
            step();
            if_valid = 1'b0;
            check_eq("after_pc",    64'(id_pc), 64'd5);
            check_eq("after_count", 64'(count), 64'd1);
            id_ready = 1'b1;
            step();
            id_ready = 1'b0;
            check_eq("after_empty", 64'(id_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_inst_queue.md
Name: if_inst_queue

Overview:
- Instruction queue between the inst_fetch stage and the decode stage.
- Buffers fetched {pc, instruction} pairs in a DEPTH-entry circular FIFO, so a decode stall does not lose fetched words.
- Valid/ready handshake on both sides.
- Flush input discards all buffered words on a branch/jump redirect.

Parameters:
NPC, 6, PC width in bits (matches inst_fetch)
NINST, 32, instruction width in bits (matches inst_fetch)
DEPTH, 4, number of queue entries; power of two, >= 2

Ports:
i_clk  input  1  single clock, all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_if_valid  input  1  fetch stage presents a word this cycle
o_if_ready  output  1  queue can accept a word this cycle
i_if_pc  input  NPC  PC of presented word
i_if_inst  input  NINST  presented instruction
i_flush  input  1  discard all queued words (redirect)
o_id_valid  output  1  head entry available to decode
i_id_ready  input  1  decode consumes head this cycle
o_id_pc  output  NPC  PC of head entry
o_id_inst  output  NINST  instruction of head entry
o_count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high. No other clocks or asynchronous resets.
- State: storage array DEPTH x (NPC+NINST), write pointer wr_ptr, read pointer rd_ptr, registered count.
  - Pointer width log2(DEPTH); pointers wrap modulo DEPTH.
- Push: occurs when i_if_valid && o_if_ready && !i_flush. The word is written at wr_ptr and wr_ptr increments.
- Pop: occurs when o_id_valid && i_id_ready && !i_flush. rd_ptr increments.
- o_if_ready = (count != DEPTH).
  - Derived only from registered count; it does not depend on i_id_ready (no full-bypass).
  - When full, a simultaneous pop does not open a push slot in the same cycle.
- o_id_valid = (count != 0).
- o_id_pc/o_id_inst = storage[rd_ptr] when count != 0, else all zeros.
- Latency: a word pushed at edge N is visible on o_id_* after edge N and can be popped in cycle N+1. There is no same-cycle fall-through from input to output.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- Count never exceeds DEPTH and never underflows. Pop when empty and push when full are blocked by the handshake and are no-ops.
- Order: strict FIFO. The word at the head is always the oldest accepted word.
- Flush (i_flush=1 at an edge):
  - wr_ptr = rd_ptr = 0 and count = 0.
  - A concurrent push is dropped and a concurrent pop is not counted. Flush has priority over both.
  - Next cycle: o_id_valid=0, o_if_ready=1.
- Reset (i_rst=1 at an edge):
  - Same state as flush: pointers 0, count 0.
  - Outputs after reset: o_id_valid=0, o_if_ready=1, o_id_pc=0, o_id_inst=0, o_count=0.
  - Reset has priority over flush and over the handshakes.
  - Storage contents need not be cleared; they are masked by count.
- Reset asserted mid-operation: all queued words are lost and there is no output activity the following cycle.
- Handshake stability: once a word is presented with i_if_valid=1 and not accepted, the upstream holds i_if_pc/i_if_inst stable. The queue itself holds o_id_* stable while o_id_valid=1 and i_id_ready=0.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles, then release -> o_id_valid=0, o_if_ready=1, o_count=0, o_id_pc=0, o_id_inst=0.
- Fill/full: i_id_ready=0, push pc 0..3 with inst 32'h1000_0000+pc -> o_count=4, o_if_ready=0. A 5th word (pc 4) is held off; o_id_pc=0 and o_id_inst=32'h1000_0000 stay stable.
- Drain order: from the full state, i_id_ready=1 and i_if_valid=0 -> o_id_pc sequence 0,1,2,3 over 4 cycles. Then o_id_valid=0 and o_count=0.
- Simultaneous push/pop: with count=2, push every cycle and pop every cycle for 8 cycles -> o_count stays 2. Popped PCs are contiguous and in order.
- Wrap-around: stream pc 0..9 with i_id_ready toggling 1,0 -> all 10 PCs appear in order, none duplicated or lost. Pointers wrap past DEPTH twice.
- Flush and reset mid-operation:
  - With count=3, assert i_flush together with a push of pc 7 -> next cycle o_count=0 and o_id_valid=0. pc 7 never appears at the output.
  - Repeat with i_rst instead of i_flush -> identical result.
